// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - time-of-day clock with weekday tracking and N snoozable alarm channels
module multi_alarm_clock #(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk_1Hz,
    input  logic                reset_n,
    input  logic                time_load,
    input  logic [4:0]          load_hours,
    input  logic [5:0]          load_minutes,
    input  logic [5:0]          load_seconds,
    input  logic [2:0]          load_day,
    input  logic                alm_wr,
    input  logic [SEL_W-1:0]    alm_sel,
    input  logic [4:0]          alm_hours,
    input  logic [5:0]          alm_minutes,
    input  logic [6:0]          alm_days,
    input  logic                alm_enable,
    input  logic                snooze,
    input  logic                dismiss,
    output logic [4:0]          hours,
    output logic [5:0]          minutes,
    output logic [5:0]          seconds,
    output logic [2:0]          day_of_week,
    output logic [N_ALARMS-1:0] ringing,
    output logic [N_ALARMS-1:0] snoozed,
    output logic                alarm_any
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ch_state_t;

    localparam logic [7:0]  RING_LOAD = 8'(RING_SEC);
    localparam logic [10:0] SNZ_LOAD  = 11'(SNOOZE_MIN * 60);

    logic [4:0]  alm_hours_q   [N_ALARMS];
    logic [5:0]  alm_minutes_q [N_ALARMS];
    logic [6:0]  alm_days_q    [N_ALARMS];
    logic [N_ALARMS-1:0] alm_en_q;

    ch_state_t   state_q  [N_ALARMS];
    ch_state_t   state_d  [N_ALARMS];
    logic [7:0]  ring_q   [N_ALARMS];
    logic [7:0]  ring_d   [N_ALARMS];
    logic [10:0] snz_q    [N_ALARMS];
    logic [10:0] snz_d    [N_ALARMS];

    logic snooze_prev;
    logic dismiss_prev;
    logic snooze_rise;
    logic dismiss_rise;
    logic alm_ok;
    logic [N_ALARMS-1:0] wr_hit;
    logic [N_ALARMS-1:0] match;

    assign snooze_rise  = snooze & ~snooze_prev;
    assign dismiss_rise = dismiss & ~dismiss_prev;
    assign alm_ok       = (alm_hours < 5'd24) && (alm_minutes < 6'd60);

    always_ff @(posedge clk_1Hz) begin
        if (!reset_n) begin
            snooze_prev  <= 1'b0;
            dismiss_prev <= 1'b0;
        end else begin
            snooze_prev  <= snooze;
            dismiss_prev <= dismiss;
        end
    end

    // Time loads are per-field: an out-of-range field keeps its previous value.
    always_ff @(posedge clk_1Hz) begin
        if (!reset_n) begin
            hours       <= 5'd0;
            minutes     <= 6'd0;
            seconds     <= 6'd0;
            day_of_week <= 3'd0;
        end else if (time_load) begin
            if (load_hours < 5'd24)   hours       <= load_hours;
            if (load_minutes < 6'd60) minutes     <= load_minutes;
            if (load_seconds < 6'd60) seconds     <= load_seconds;
            if (load_day < 3'd7)      day_of_week <= load_day;
        end else if (seconds != 6'd59) begin
            seconds <= seconds + 6'd1;
        end else begin
            seconds <= 6'd0;
            if (minutes != 6'd59) begin
                minutes <= minutes + 6'd1;
            end else begin
                minutes <= 6'd0;
                if (hours != 5'd23) begin
                    hours <= hours + 5'd1;
                end else begin
                    hours       <= 5'd0;
                    day_of_week <= (day_of_week == 3'd6) ? 3'd0 : day_of_week + 3'd1;
                end
            end
        end
    end

    always_comb begin
        wr_hit = '0;
        match  = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            wr_hit[i] = alm_wr && alm_ok && (alm_sel == SEL_W'(i));
            match[i]  = alm_en_q[i] && alm_days_q[i][day_of_week] &&
                        (alm_hours_q[i] == hours) && (alm_minutes_q[i] == minutes) &&
                        (seconds == 6'd0) && !time_load;
        end
    end

    always_ff @(posedge clk_1Hz) begin
        for (int i = 0; i < N_ALARMS; i++) begin
            if (!reset_n) begin
                alm_hours_q[i]   <= 5'd0;
                alm_minutes_q[i] <= 6'd0;
                alm_days_q[i]    <= 7'd0;
                alm_en_q[i]      <= 1'b0;
                state_q[i]       <= IDLE;
                ring_q[i]        <= 8'd0;
                snz_q[i]         <= 11'd0;
            end else begin
                if (wr_hit[i]) begin
                    alm_hours_q[i]   <= alm_hours;
                    alm_minutes_q[i] <= alm_minutes;
                    alm_days_q[i]    <= alm_days;
                    alm_en_q[i]      <= alm_enable;
                end
                state_q[i] <= state_d[i];
                ring_q[i]  <= ring_d[i];
                snz_q[i]   <= snz_d[i];
            end
        end
    end

    // Branch order inside each state encodes the priority: write > dismiss > snooze > expiry > match.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            state_d[i] = state_q[i];
            ring_d[i]  = ring_q[i];
            snz_d[i]   = snz_q[i];
            if (wr_hit[i]) begin
                state_d[i] = IDLE;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (match[i]) begin
                            state_d[i] = RINGING;
                            ring_d[i]  = RING_LOAD;
                        end
                    end
                    RINGING: begin
                        if (dismiss_rise) begin
                            state_d[i] = IDLE;
                        end else if (snooze_rise) begin
                            state_d[i] = SNOOZED;
                            snz_d[i]   = SNZ_LOAD;
                        end else if (ring_q[i] == 8'd1) begin
                            state_d[i] = IDLE;
                        end else begin
                            ring_d[i] = ring_q[i] - 8'd1;
                        end
                    end
                    SNOOZED: begin
                        if (dismiss_rise) begin
                            state_d[i] = IDLE;
                        end else if (snz_q[i] == 11'd1) begin
                            state_d[i] = RINGING;
                            ring_d[i]  = RING_LOAD;
                        end else begin
                            snz_d[i] = snz_q[i] - 11'd1;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ringing = '0;
        snoozed = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            ringing[i] = (state_q[i] == RINGING);
            snoozed[i] = (state_q[i] == SNOOZED);
        end
    end

    assign alarm_any = |ringing;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - directed self-checking bench for multi_alarm_clock
module tb_multi_alarm_clock;

    logic       clk_1Hz = 1'b0;
    logic       reset_n;
    logic       time_load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic [5:0] load_seconds;
    logic [2:0] load_day;
    logic       alm_wr;
    logic [1:0] alm_sel;
    logic [4:0] alm_hours;
    logic [5:0] alm_minutes;
    logic [6:0] alm_days;
    logic       alm_enable;
    logic       snooze;
    logic       dismiss;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [2:0] day_of_week;
    logic [3:0] ringing;
    logic [3:0] snoozed;
    logic       alarm_any;

    int checks   = 0;
    int failures = 0;

    multi_alarm_clock #(.N_ALARMS(4), .SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk_1Hz(clk_1Hz), .reset_n(reset_n), .time_load(time_load),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .load_day(load_day),
        .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_hours(alm_hours),
        .alm_minutes(alm_minutes), .alm_days(alm_days), .alm_enable(alm_enable),
        .snooze(snooze), .dismiss(dismiss),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .day_of_week(day_of_week), .ringing(ringing), .snoozed(snoozed),
        .alarm_any(alarm_any)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_1Hz);
    endtask

    task automatic load_time(input logic [4:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic [2:0] d);
        time_load    = 1'b1;
        load_hours   = h;
        load_minutes = m;
        load_seconds = s;
        load_day     = d;
        step(1);
        time_load = 1'b0;
    endtask

    task automatic write_alarm(input logic [1:0] sel, input logic [4:0] h,
                               input logic [5:0] m, input logic [6:0] days);
        alm_wr      = 1'b1;
        alm_sel     = sel;
        alm_hours   = h;
        alm_minutes = m;
        alm_days    = days;
        alm_enable  = 1'b1;
        step(1);
        alm_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; time_load = 1'b0;
        load_hours = '0; load_minutes = '0; load_seconds = '0; load_day = '0;
        alm_wr = 1'b0; alm_sel = '0; alm_hours = '0; alm_minutes = '0;
        alm_days = '0; alm_enable = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        @(negedge clk_1Hz);
        step(2);
        check("rst_time", {hours, minutes, seconds, day_of_week}, 32'h0);
        check("rst_flags", {ringing, snoozed, alarm_any}, 32'h0);
        reset_n = 1'b1;

        // Midnight rollover with day wrap
        load_time(5'd23, 6'd59, 6'd58, 3'd6);
        check("load_sec", seconds, 58);
        check("load_day", day_of_week, 6);
        step(2);
        check("roll_hms", {hours, minutes, seconds}, 32'h0);
        check("roll_day", day_of_week, 0);

        // Match then auto-silence after 60 ringing cycles
        write_alarm(2'd0, 5'd7, 6'd30, 7'h7F);
        load_time(5'd7, 6'd29, 6'd59, 3'd0);
        step(1);
        check("at_0730_00_min", minutes, 30);
        check("at_0730_00_ring", ringing, 4'b0000);
        step(1);
        check("ring_start", ringing, 4'b0001);
        check("alarm_any", alarm_any, 1);
        step(59);
        check("ring_last", ringing, 4'b0001);
        step(1);
        check("auto_silence", ringing, 4'b0000);

        // Snooze for 300 cycles, re-ring, then dismiss
        load_time(5'd7, 6'd29, 6'd59, 3'd0);
        step(2);
        check("ring_again", ringing, 4'b0001);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        check("snz_flag", snoozed, 4'b0001);
        check("snz_ring", ringing, 4'b0000);
        step(299);
        check("snz_last", {ringing, snoozed}, 8'h01);
        step(1);
        check("snz_expire", {ringing, snoozed}, 8'h10);
        dismiss = 1'b1;
        step(1);
        dismiss = 1'b0;
        check("dismiss", {ringing, snoozed}, 8'h00);

        // Weekday mask: Monday only
        write_alarm(2'd1, 5'd8, 6'd0, 7'b0000001);
        load_time(5'd7, 6'd59, 6'd59, 3'd1);
        step(2);
        check("mask_day1", ringing, 4'b0000);
        load_time(5'd7, 6'd59, 6'd59, 3'd0);
        step(2);
        check("mask_day0", ringing, 4'b0010);

        // Snooze and dismiss together resolve to IDLE
        snooze = 1'b1; dismiss = 1'b1;
        step(1);
        snooze = 1'b0; dismiss = 1'b0;
        check("conflict", {ringing, snoozed}, 8'h00);

        // Dropped write leaves the channel ringing; valid write forces IDLE
        load_time(5'd7, 6'd59, 6'd59, 3'd0);
        step(2);
        check("ring_ch1", ringing, 4'b0010);
        write_alarm(2'd1, 5'd24, 6'd0, 7'b0000001);
        check("bad_wr_kept", ringing, 4'b0010);
        write_alarm(2'd1, 5'd8, 6'd0, 7'b0000001);
        check("wr_idle", ringing, 4'b0000);

        // Out-of-range hour load keeps hour; time frozen while load held
        time_load = 1'b1; load_hours = 5'd24; load_minutes = 6'd10;
        load_seconds = 6'd5; load_day = 3'd0;
        step(2);
        check("bad_ld_hr", hours, 8);
        check("bad_ld_min", minutes, 10);
        check("hold_sec", seconds, 5);
        time_load = 1'b0;

        // Reset mid-ring
        load_time(5'd7, 6'd59, 6'd59, 3'd0);
        step(2);
        check("ring_pre_rst", ringing, 4'b0010);
        reset_n = 1'b0;
        step(1);
        check("rst_mid_time", {hours, minutes, seconds, day_of_week}, 32'h0);
        check("rst_mid_flags", {ringing, snoozed, alarm_any}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
